// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: latches the secret, hands guesses to an external peg
// evaluator, totals its flags and tracks tries / win / lose. Optional macro: RAND_SECRET_EN.
module mastermind_game_ctrl #(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic [7:0]       secret_in,
  input  logic             secret_load,
  input  logic [7:0]       guess_in,
  input  logic             guess_valid,
  output logic             guess_ready,
  output logic [7:0]       eval_a,
  output logic [7:0]       eval_b,
  input  logic [3:0]       eval_c,
  input  logic [3:0]       eval_m,
  output logic [2:0]       exact_cnt,
  output logic [2:0]       partial_cnt,
  output logic             result_valid,
  output logic [TRY_W-1:0] tries,
  output logic             win,
  output logic             lose
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_EVAL  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       eval_a_q, eval_a_d;
  logic [7:0]       eval_b_q, eval_b_d;
  logic [2:0]       exact_q, exact_d;
  logic [2:0]       partial_q, partial_d;
  logic             result_valid_q, result_valid_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic [7:0]       secret_src_s;
  logic [TRY_W-1:0] tries_inc_s;
  logic [2:0]       exact_s;
  logic [2:0]       partial_s;

`ifdef RAND_SECRET_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR used as the secret source
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, seeded on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign secret_src_s = lfsr_q;
`else
  assign secret_src_s = secret_in;
`endif

  assign tries_inc_s = tries_q + TRY_W'(1);
  assign exact_s     = popcount4(eval_c);
  assign partial_s   = popcount4(eval_m);

  // Next-state and next-output logic; new_game overrides everything
  always_comb begin
    state_d        = state_q;
    eval_a_d       = eval_a_q;
    eval_b_d       = eval_b_q;
    exact_d        = exact_q;
    partial_d      = partial_q;
    tries_d        = tries_q;
    win_d          = win_q;
    lose_d         = lose_q;
    result_valid_d = 1'b0;
    if (new_game) begin
      state_d   = S_IDLE;
      eval_a_d  = 8'h00;
      eval_b_d  = 8'h00;
      exact_d   = 3'd0;
      partial_d = 3'd0;
      tries_d   = '0;
      win_d     = 1'b0;
      lose_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (secret_load) begin
            eval_b_d = secret_src_s;
            state_d  = S_READY;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_READY: begin
          if (guess_valid) begin
            eval_a_d = guess_in;
            state_d  = S_EVAL;
          end else begin
            state_d  = S_READY;
          end
        end
        // Evaluator has had one full cycle to settle on eval_a/eval_b
        S_EVAL: begin
          exact_d        = exact_s;
          partial_d      = partial_s;
          tries_d        = tries_inc_s;
          result_valid_d = 1'b1;
          if (exact_s == 3'd4) begin
            state_d = S_WIN;
            win_d   = 1'b1;
          end else if (tries_inc_s == TRY_W'(MAX_TRIES)) begin
            state_d = S_LOSE;
            lose_d  = 1'b1;
          end else begin
            state_d = S_READY;
          end
        end
        S_WIN: begin
          state_d = S_WIN;
          win_d   = 1'b1;
        end
        S_LOSE: begin
          state_d = S_LOSE;
          lose_d  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      eval_a_q       <= 8'h00;
      eval_b_q       <= 8'h00;
      exact_q        <= 3'd0;
      partial_q      <= 3'd0;
      tries_q        <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      eval_a_q       <= eval_a_d;
      eval_b_q       <= eval_b_d;
      exact_q        <= exact_d;
      partial_q      <= partial_d;
      tries_q        <= tries_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign guess_ready  = (state_q == S_READY);
  assign eval_a       = eval_a_q;
  assign eval_b       = eval_b_q;
  assign exact_cnt    = exact_q;
  assign partial_cnt  = partial_q;
  assign result_valid = result_valid_q;
  assign tries        = tries_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: doc/mastermind_game_ctrl.md
Name: mastermind_game_ctrl

Overview:
- Sequences one Mastermind-style game around the external 4-peg, 2-bit-per-peg code evaluator.
- Holds the secret code and accepts guesses one at a time through a valid/ready handshake.
- Drives the evaluator with the registered guess and secret, and counts its per-peg exact (c) and colour-only (m) flags into totals.
- Tracks the number of attempts and declares win or lose; sits between the switch/key input logic and the display logic.

Parameters:
MAX_TRIES, 10, guesses allowed per game (1..2**TRY_W-1)
TRY_W, 4, width of attempt counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
new_game  in  1  one-cycle pulse; abort and return to IDLE
secret_in  in  8  secret code, peg k = bits [2k+1:2k]
secret_load  in  1  one-cycle pulse; latch secret_in (honoured in IDLE only)
guess_in  in  8  guess code, same packing
guess_valid  in  1  guess offered
guess_ready  out  1  controller can accept a guess
eval_a  out  8  registered guess to evaluator input a
eval_b  out  8  registered secret to evaluator input b
eval_c  in  4  evaluator exact-position flags
eval_m  in  4  evaluator colour-only flags
exact_cnt  out  3  popcount(eval_c) of last guess, 0..4
partial_cnt  out  3  popcount(eval_m) of last guess, 0..4
result_valid  out  1  one-cycle pulse: counts updated
tries  out  TRY_W  guesses evaluated this game
win  out  1  sticky, game won
lose  out  1  sticky, game lost

Behaviour:
- Reset (reset=0, async): state=IDLE; eval_a, eval_b, exact_cnt, partial_cnt, tries = 0; result_valid, win, lose, guess_ready = 0.
- States: IDLE, READY, EVAL, WIN, LOSE. guess_ready = (state==READY), combinational from state.
- IDLE: on secret_load, eval_b <= secret_in and go to READY. All other inputs are ignored.
- READY: on guess_valid && guess_ready, eval_a <= guess_in and go to EVAL. guess_valid while not ready is dropped, not queued.
- EVAL lasts exactly 1 cycle while the combinational evaluator settles. At the closing edge:
  - exact_cnt <= popcount(eval_c); partial_cnt <= popcount(eval_m); tries <= tries+1; result_valid <= 1 for one cycle.
  - Next state: WIN if popcount(eval_c)==4; else LOSE if tries+1==MAX_TRIES; else READY.
- Latency: guess accepted at edge N -> counts and result_valid visible in cycle N+2. Back-to-back guesses are allowed, so guess_ready can be high in the same cycle as result_valid.
- WIN: win=1, sticky. LOSE: lose=1, sticky. Both states hold until new_game or reset. guess_ready=0; secret_load and guess_valid are ignored.
- Win on the final try: WIN takes priority; lose stays 0.
- new_game (any state) has priority over every other input. It clears tries, exact_cnt, partial_cnt, win, lose, eval_a and eval_b, forces IDLE, and cancels an in-flight EVAL: no result_valid and no tries increment.
- new_game and secret_load in the same cycle: new_game wins and the secret is not loaded.
- exact_cnt/partial_cnt hold their last value between results. tries never wraps: the maximum value is MAX_TRIES.
- eval_b is stable for the whole game. eval_a changes only on guess acceptance.

Optional Feature:
RAND_SECRET_EN
- Defined:
  - Adds an internal 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1.
  - Reset seed 8'hA5; the LFSR steps every cycle regardless of state.
  - secret_load in IDLE latches the current LFSR value into eval_b; secret_in is ignored.
- Undefined: no LFSR; secret_in is latched exactly as above.

Test Plan:
1. Reset, then secret_load with secret_in=8'h1B, then guess 8'h1B -> result_valid pulses 2 cycles after acceptance; exact_cnt=4, partial_cnt=0, tries=1, win=1, guess_ready=0.
2. Secret 8'h1B, guess 8'hE4 (all pegs reversed) -> exact_cnt=0, partial_cnt=4, tries=1, state back to READY, win=lose=0.
3. Secret 8'h1B, 10 guesses of 8'h00 -> each result exact_cnt=1, partial_cnt=0. After the 10th: tries=10, lose=1, guess_ready=0, and an 11th guess_valid is ignored.
4. Secret 8'h1B, 9 wrong guesses then 8'h1B -> win=1, lose=0, tries=10.
5. Assert new_game during the EVAL cycle -> no result_valid; tries=0, state IDLE. A secret_load in the same cycle as new_game is ignored.
6. Drive reset low asynchronously mid-EVAL, between clock edges -> all outputs 0 immediately. With RAND_SECRET_EN, the first secret_load after reset latches the deterministic LFSR value for that cycle count.
